// File: rtl/stage_1_pair_scheduler.sv
// Issue controller ahead of the stage-1 LUT/scaling datapath.
// Two back-to-back bools with the same probability share one issue slot.
// Any other symbol, or a bool that finds no partner, issues alone.
module stage_1_pair_scheduler #(
  parameter int unsigned RANGE_WIDTH  = 16,
  parameter int unsigned SYMBOL_WIDTH = 4,
  parameter int unsigned TIMEOUT      = 8,
  parameter int unsigned TMR_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RANGE_WIDTH-1:0]  in_fl,
  input  logic [RANGE_WIDTH-1:0]  in_fh,
  input  logic [SYMBOL_WIDTH-1:0] in_symbol,
  input  logic [SYMBOL_WIDTH:0]   in_nsyms,
  input  logic                    in_bool,
  input  logic                    in_flush,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [RANGE_WIDTH-1:0]  out_fl,
  output logic [RANGE_WIDTH-1:0]  out_fh,
  output logic [SYMBOL_WIDTH-1:0] out_symbol_1,
  output logic [SYMBOL_WIDTH-1:0] out_symbol_2,
  output logic [SYMBOL_WIDTH:0]   out_nsyms,
  output logic                    out_bool_flag_1,
  output logic                    out_bool_flag_2,
  output logic                    out_pair,
  output logic                    hold_busy
);

  localparam int unsigned NSYM_WIDTH = SYMBOL_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [TMR_WIDTH-1:0]    timer_q, timer_d;

  // held bool waiting for a partner
  logic [RANGE_WIDTH-1:0]  hold_fl_q, hold_fl_d;
  logic [RANGE_WIDTH-1:0]  hold_fh_q, hold_fh_d;
  logic                    hold_sym_q, hold_sym_d;

  // symbol parked behind a forced single issue
  logic [RANGE_WIDTH-1:0]  pend_fl_q, pend_fl_d;
  logic [RANGE_WIDTH-1:0]  pend_fh_q, pend_fh_d;
  logic [SYMBOL_WIDTH-1:0] pend_sym_q, pend_sym_d;
  logic [NSYM_WIDTH-1:0]   pend_nsyms_q, pend_nsyms_d;
  logic                    pend_bool_q, pend_bool_d;

  // issue slot register
  logic                    out_valid_q, out_valid_d;
  logic [RANGE_WIDTH-1:0]  out_fl_q, out_fl_d;
  logic [RANGE_WIDTH-1:0]  out_fh_q, out_fh_d;
  logic [SYMBOL_WIDTH-1:0] out_sym1_q, out_sym1_d;
  logic [SYMBOL_WIDTH-1:0] out_sym2_q, out_sym2_d;
  logic [NSYM_WIDTH-1:0]   out_nsyms_q, out_nsyms_d;
  logic                    out_flag1_q, out_flag1_d;
  logic                    out_flag2_q, out_flag2_d;
  logic                    out_pair_q, out_pair_d;
  logic                    hold_busy_q, hold_busy_d;

  // issue request built by the scheduler this cycle
  logic                    iss_c;
  logic [RANGE_WIDTH-1:0]  iss_fl_c, iss_fh_c;
  logic [SYMBOL_WIDTH-1:0] iss_sym1_c, iss_sym2_c;
  logic [NSYM_WIDTH-1:0]   iss_nsyms_c;
  logic                    iss_flag1_c, iss_flag2_c, iss_pair_c;

  logic free_c;
  logic accept_c;
  logic timeout_c;

  // handshake: the slot register may load when empty or being drained
  always_comb begin
    free_c    = !out_valid_q || out_ready;
    in_ready  = free_c && (state_q != S_DRAIN);
    accept_c  = in_valid && in_ready;
    timeout_c = (timer_q == TMR_WIDTH'(TIMEOUT));
  end

  // next-state, hold/pend capture and issue selection
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    hold_fl_d    = hold_fl_q;
    hold_fh_d    = hold_fh_q;
    hold_sym_d   = hold_sym_q;
    pend_fl_d    = pend_fl_q;
    pend_fh_d    = pend_fh_q;
    pend_sym_d   = pend_sym_q;
    pend_nsyms_d = pend_nsyms_q;
    pend_bool_d  = pend_bool_q;
    iss_c        = 1'b0;
    iss_fl_c     = '0;
    iss_fh_c     = '0;
    iss_sym1_c   = '0;
    iss_sym2_c   = '0;
    iss_nsyms_c  = '0;
    iss_flag1_c  = 1'b1;
    iss_flag2_c  = 1'b1;
    iss_pair_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (!in_bool) begin
            iss_c       = 1'b1;
            iss_fl_c    = in_fl;
            iss_fh_c    = in_fh;
            iss_sym1_c  = in_symbol;
            iss_nsyms_c = in_nsyms;
          end else if (in_flush) begin
            iss_c       = 1'b1;
            iss_fl_c    = in_fl;
            iss_fh_c    = in_fh;
            iss_sym1_c  = SYMBOL_WIDTH'(in_symbol[0]);
            iss_nsyms_c = NSYM_WIDTH'(2);
            iss_flag1_c = 1'b0;
          end else begin
            hold_fl_d  = in_fl;
            hold_fh_d  = in_fh;
            hold_sym_d = in_symbol[0];
            timer_d    = '0;
            state_d    = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (accept_c) begin
          iss_c       = 1'b1;
          iss_fl_c    = hold_fl_q;
          iss_fh_c    = hold_fh_q;
          iss_sym1_c  = SYMBOL_WIDTH'(hold_sym_q);
          iss_nsyms_c = NSYM_WIDTH'(2);
          iss_flag1_c = 1'b0;
          if (in_bool && (in_fl == hold_fl_q)) begin
            iss_sym2_c  = SYMBOL_WIDTH'(in_symbol[0]);
            iss_flag2_c = 1'b0;
            iss_pair_c  = 1'b1;
            state_d     = S_IDLE;
          end else if (in_bool && !in_flush) begin
            hold_fl_d  = in_fl;
            hold_fh_d  = in_fh;
            hold_sym_d = in_symbol[0];
            timer_d    = '0;
          end else begin
            pend_fl_d    = in_fl;
            pend_fh_d    = in_fh;
            pend_sym_d   = in_symbol;
            pend_nsyms_d = in_nsyms;
            pend_bool_d  = in_bool;
            state_d      = S_DRAIN;
          end
        end else if ((timeout_c || in_flush) && free_c) begin
          iss_c       = 1'b1;
          iss_fl_c    = hold_fl_q;
          iss_fh_c    = hold_fh_q;
          iss_sym1_c  = SYMBOL_WIDTH'(hold_sym_q);
          iss_nsyms_c = NSYM_WIDTH'(2);
          iss_flag1_c = 1'b0;
          timer_d     = '0;
          state_d     = S_IDLE;
        end else if (!timeout_c) begin
          timer_d = timer_q + TMR_WIDTH'(1);
        end
      end

      S_DRAIN: begin
        if (free_c) begin
          iss_c    = 1'b1;
          iss_fl_c = pend_fl_q;
          iss_fh_c = pend_fh_q;
          if (pend_bool_q) begin
            iss_sym1_c  = SYMBOL_WIDTH'(pend_sym_q[0]);
            iss_nsyms_c = NSYM_WIDTH'(2);
            iss_flag1_c = 1'b0;
          end else begin
            iss_sym1_c  = pend_sym_q;
            iss_nsyms_c = pend_nsyms_q;
          end
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // issue slot load: only when free, otherwise every field holds
  always_comb begin
    out_valid_d = out_valid_q;
    out_fl_d    = out_fl_q;
    out_fh_d    = out_fh_q;
    out_sym1_d  = out_sym1_q;
    out_sym2_d  = out_sym2_q;
    out_nsyms_d = out_nsyms_q;
    out_flag1_d = out_flag1_q;
    out_flag2_d = out_flag2_q;
    out_pair_d  = out_pair_q;
    hold_busy_d = (state_d == S_HOLD);
    if (free_c) begin
      out_valid_d = iss_c;
      if (iss_c) begin
        out_fl_d    = iss_fl_c;
        out_fh_d    = iss_fh_c;
        out_sym1_d  = iss_sym1_c;
        out_sym2_d  = iss_sym2_c;
        out_nsyms_d = iss_nsyms_c;
        out_flag1_d = iss_flag1_c;
        out_flag2_d = iss_flag2_c;
        out_pair_d  = iss_pair_c;
      end
    end
  end

  // state and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      hold_fl_q    <= '0;
      hold_fh_q    <= '0;
      hold_sym_q   <= 1'b0;
      pend_fl_q    <= '0;
      pend_fh_q    <= '0;
      pend_sym_q   <= '0;
      pend_nsyms_q <= '0;
      pend_bool_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_fl_q     <= '0;
      out_fh_q     <= '0;
      out_sym1_q   <= '0;
      out_sym2_q   <= '0;
      out_nsyms_q  <= '0;
      out_flag1_q  <= 1'b1;
      out_flag2_q  <= 1'b1;
      out_pair_q   <= 1'b0;
      hold_busy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      hold_fl_q    <= hold_fl_d;
      hold_fh_q    <= hold_fh_d;
      hold_sym_q   <= hold_sym_d;
      pend_fl_q    <= pend_fl_d;
      pend_fh_q    <= pend_fh_d;
      pend_sym_q   <= pend_sym_d;
      pend_nsyms_q <= pend_nsyms_d;
      pend_bool_q  <= pend_bool_d;
      out_valid_q  <= out_valid_d;
      out_fl_q     <= out_fl_d;
      out_fh_q     <= out_fh_d;
      out_sym1_q   <= out_sym1_d;
      out_sym2_q   <= out_sym2_d;
      out_nsyms_q  <= out_nsyms_d;
      out_flag1_q  <= out_flag1_d;
      out_flag2_q  <= out_flag2_d;
      out_pair_q   <= out_pair_d;
      hold_busy_q  <= hold_busy_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_fl          = out_fl_q;
  assign out_fh          = out_fh_q;
  assign out_symbol_1    = out_sym1_q;
  assign out_symbol_2    = out_sym2_q;
  assign out_nsyms       = out_nsyms_q;
  assign out_bool_flag_1 = out_flag1_q;
  assign out_bool_flag_2 = out_flag2_q;
  assign out_pair        = out_pair_q;
  assign hold_busy       = hold_busy_q;

endmodule

// File: tb/tb_stage_1_pair_scheduler.sv
// Bench for stage_1_pair_scheduler: reference model predicts issue slots and
// handshake levels; a monitor pops predicted slots as the DUT hands them off.
module tb_stage_1_pair_scheduler;

  localparam int unsigned TO = 8;

  typedef struct packed {
    logic [15:0] fl;
    logic [15:0] fh;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [4:0]  nsyms;
    logic        f1;
    logic        f2;
    logic        pair;
  } slot_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] in_fl, in_fh;
  logic [3:0]  in_symbol;
  logic [4:0]  in_nsyms;
  logic        in_bool, in_flush;
  logic        out_ready, out_valid;
  logic [15:0] out_fl, out_fh;
  logic [3:0]  out_symbol_1, out_symbol_2;
  logic [4:0]  out_nsyms;
  logic        out_bool_flag_1, out_bool_flag_2, out_pair, hold_busy;

  int tests = 0;
  int fails = 0;
  int stall_mode = 0;

  slot_t exp_q[$];

  always #5 clk = ~clk;

  stage_1_pair_scheduler #(
    .RANGE_WIDTH (16),
    .SYMBOL_WIDTH(4),
    .TIMEOUT     (TO),
    .TMR_WIDTH   (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_fl          (in_fl),
    .in_fh          (in_fh),
    .in_symbol      (in_symbol),
    .in_nsyms       (in_nsyms),
    .in_bool        (in_bool),
    .in_flush       (in_flush),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_fl         (out_fl),
    .out_fh         (out_fh),
    .out_symbol_1   (out_symbol_1),
    .out_symbol_2   (out_symbol_2),
    .out_nsyms      (out_nsyms),
    .out_bool_flag_1(out_bool_flag_1),
    .out_bool_flag_2(out_bool_flag_2),
    .out_pair       (out_pair),
    .hold_busy      (hold_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic slot_t mk_bool(input logic [15:0] fl, input logic [15:0] fh, input logic b);
    slot_t s;
    s.fl = fl; s.fh = fh; s.s1 = {3'b000, b}; s.s2 = 4'd0; s.nsyms = 5'd2;
    s.f1 = 1'b0; s.f2 = 1'b1; s.pair = 1'b0;
    return s;
  endfunction

  function automatic slot_t mk_nb(input logic [15:0] fl, input logic [15:0] fh,
                                  input logic [3:0] sym, input logic [4:0] ns);
    slot_t s;
    s.fl = fl; s.fh = fh; s.s1 = sym; s.s2 = 4'd0; s.nsyms = ns;
    s.f1 = 1'b1; s.f2 = 1'b1; s.pair = 1'b0;
    return s;
  endfunction

  // reference model: a slot presented or not, an optional held bool with its age,
  // and an optional symbol waiting behind a forced single issue
  logic        m_valid = 1'b0;
  logic        m_has_held = 1'b0;
  logic [15:0] m_hfl, m_hfh;
  logic        m_hsym;
  int          m_age = 0;
  logic        m_has_pend = 1'b0;
  slot_t       m_pend;

  always @(negedge clk) begin
    logic  free, rdy, acc, iss;
    slot_t s;
    if (!reset) begin
      m_valid = 1'b0; m_has_held = 1'b0; m_has_pend = 1'b0; m_age = 0;
      exp_q.delete();
    end else begin
      free = !m_valid || out_ready;
      rdy  = free && !m_has_pend;
      check("in_ready", 64'(in_ready), 64'(rdy));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("hold_busy", 64'(hold_busy), 64'(m_has_held));
      acc = in_valid && rdy;
      iss = 1'b0;
      s   = '0;
      if (m_has_pend) begin
        if (free) begin s = m_pend; iss = 1'b1; m_has_pend = 1'b0; end
      end else if (m_has_held) begin
        if (acc) begin
          iss = 1'b1;
          s   = mk_bool(m_hfl, m_hfh, m_hsym);
          if (in_bool && in_fl == m_hfl) begin
            s.s2 = {3'b000, in_symbol[0]}; s.f2 = 1'b0; s.pair = 1'b1;
            m_has_held = 1'b0;
          end else if (in_bool && !in_flush) begin
            m_hfl = in_fl; m_hfh = in_fh; m_hsym = in_symbol[0]; m_age = 0;
          end else begin
            m_has_held = 1'b0; m_has_pend = 1'b1;
            m_pend = in_bool ? mk_bool(in_fl, in_fh, in_symbol[0])
                             : mk_nb(in_fl, in_fh, in_symbol, in_nsyms);
          end
        end else if ((m_age == TO || in_flush) && free) begin
          iss = 1'b1; s = mk_bool(m_hfl, m_hfh, m_hsym); m_has_held = 1'b0;
        end else if (m_age < TO) begin
          m_age++;
        end
      end else if (acc) begin
        if (!in_bool) begin
          iss = 1'b1; s = mk_nb(in_fl, in_fh, in_symbol, in_nsyms);
        end else if (in_flush) begin
          iss = 1'b1; s = mk_bool(in_fl, in_fh, in_symbol[0]);
        end else begin
          m_has_held = 1'b1; m_hfl = in_fl; m_hfh = in_fh; m_hsym = in_symbol[0]; m_age = 0;
        end
      end
      if (iss) exp_q.push_back(s);
      if (free) m_valid = iss;
    end
  end

  // monitor: compare each handed-off slot in order; stalled slots must not change
  slot_t prev_slot;
  logic  prev_stall = 1'b0;

  always @(negedge clk) begin
    slot_t cur, e;
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      cur = {out_fl, out_fh, out_symbol_1, out_symbol_2, out_nsyms,
             out_bool_flag_1, out_bool_flag_2, out_pair};
      if (prev_stall) check("stall_stable", 64'(cur), 64'(prev_slot));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL slot_unexpected: got %0h expected none at %0t", cur, $time);
        end else begin
          e = exp_q.pop_front();
          check("slot", 64'(cur), 64'(e));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_slot  = cur;
    end
  end

  // downstream ready pattern
  always @(posedge clk) begin
    #1;
    case (stall_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [15:0] fl, input logic [15:0] fh, input logic [3:0] sym,
                      input logic [4:0] ns, input logic b, input logic fls);
    logic r;
    logic done;
    done = 1'b0;
    in_valid = 1'b1; in_fl = fl; in_fh = fh; in_symbol = sym;
    in_nsyms = ns; in_bool = b; in_flush = fls;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) begin done = 1'b1; break; end
    end
    in_valid = 1'b0; in_flush = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL send_timeout: got no accept expected accept at %0t", $time);
    end
  endtask

  task automatic flush_pulse();
    in_flush = 1'b1;
    idle(1);
    in_flush = 1'b0;
  endtask

  initial begin
    logic [15:0] f;
    int          r;
    reset = 1'b0; in_valid = 1'b0; in_fl = '0; in_fh = '0; in_symbol = '0;
    in_nsyms = '0; in_bool = 1'b0; in_flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(1);

    // non-bool, latency 1
    send(16'h4000, 16'h2000, 4'd3, 5'd5, 1'b0, 1'b0); idle(2);
    // matched pair
    send(16'h6000, 16'h1111, 4'd1, 5'd2, 1'b1, 1'b0);
    send(16'h6000, 16'h2222, 4'd0, 5'd2, 1'b1, 1'b0); idle(2);
    // mismatched fl: first issues alone, second held
    send(16'h6000, 16'h1111, 4'd1, 5'd2, 1'b1, 1'b0);
    send(16'h3000, 16'h0800, 4'd0, 5'd2, 1'b1, 1'b0); idle(1);
    // held bool then non-bool: drain path
    send(16'h1234, 16'h0100, 4'd7, 5'd9, 1'b0, 1'b0); idle(3);
    // timeout
    send(16'h6000, 16'h0aaa, 4'd1, 5'd2, 1'b1, 1'b0); idle(12);
    // flush pulse while holding
    send(16'h6000, 16'h0bbb, 4'd0, 5'd2, 1'b1, 1'b0); idle(1); flush_pulse(); idle(2);
    // bool with flush from idle, then mismatched bool with flush from hold
    send(16'h2000, 16'h0c00, 4'd3, 5'd7, 1'b1, 1'b1); idle(1);
    send(16'h6000, 16'h0d00, 4'd1, 5'd2, 1'b1, 1'b0);
    send(16'h3000, 16'h0e00, 4'd0, 5'd2, 1'b1, 1'b1); idle(3);
    // pair issued into a 5-cycle stall
    stall_mode = 2; idle(1);
    send(16'h5000, 16'h0f00, 4'd1, 5'd2, 1'b1, 1'b0);
    send(16'h5000, 16'h0f10, 4'd1, 5'd2, 1'b1, 1'b0);
    idle(5); stall_mode = 0; idle(3);
    // reset while holding
    send(16'h6000, 16'h0123, 4'd1, 5'd2, 1'b1, 1'b0); idle(2);
    reset = 1'b0; idle(1); reset = 1'b1; idle(3);

    // randomized traffic with random stalls
    stall_mode = 1;
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        case ($urandom_range(0, 2))
          0:       f = 16'h6000;
          1:       f = 16'h3000;
          default: f = 16'h5000;
        endcase
        send(f, 16'($urandom), 4'($urandom), 5'($urandom_range(2, 16)),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
      end else if (r == 7) begin
        idle(int'($urandom_range(1, 12)));
      end else begin
        flush_pulse();
      end
    end

    stall_mode = 0;
    idle(20);
    check("drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
